// File: rtl/eth_pkg.sv
// Shared Ethernet-lite frame definitions used by the byte-serial TX and RX blocks.
package eth_pkg;

   localparam int unsigned ETH_FRAME_BYTES = 18;
   localparam int unsigned ETH_ADDR_BYTES  = 6;
   localparam int unsigned ETH_TYPE_BYTES  = 2;
   localparam int unsigned ETH_DATA_BYTES  = 4;

   localparam int unsigned ETH_BYTE_W  = 8;
   localparam int unsigned ETH_ADDR_W  = ETH_ADDR_BYTES * ETH_BYTE_W;
   localparam int unsigned ETH_TYPE_W  = ETH_TYPE_BYTES * ETH_BYTE_W;
   localparam int unsigned ETH_DATA_W  = ETH_DATA_BYTES * ETH_BYTE_W;
   localparam int unsigned ETH_FRAME_W = ETH_FRAME_BYTES * ETH_BYTE_W;
   localparam int unsigned ETH_CNT_W   = 5;

   localparam logic [ETH_ADDR_W-1:0] ETH_BROADCAST = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      SYNC    = 2'd0,
      IDLE    = 2'd1,
      RECV    = 2'd2,
      OVERRUN = 2'd3
   } rx_state_e;

endpackage

// File: rtl/eth_addr_filter.sv
// Destination address filter: station match, broadcast, or promiscuous accept.
module eth_addr_filter
   import eth_pkg::*;
(
   input  logic [ETH_ADDR_W-1:0] dest_i,
   input  logic [ETH_ADDR_W-1:0] mac_addr_i,
   input  logic                  promisc_i,
   output logic                  accept_c
);

   always_comb begin
      accept_c = promisc_i || (dest_i == mac_addr_i) || (dest_i == ETH_BROADCAST);
   end

endmodule

// File: rtl/frame_reception.sv
// Byte-serial frame receiver: rebuilds dest/src/type/data from an 18-byte stream,
// length-checks and address-filters it, and reports one result pulse per frame.
module frame_reception
   import eth_pkg::*;
#(
   parameter logic [ETH_ADDR_W-1:0] MAC_ADDR = 48'h1234_5678_9ABC,
   parameter bit                    PROMISC  = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_en,
   input  logic [ETH_BYTE_W-1:0] rx_in,
   output logic [ETH_ADDR_W-1:0] dest_addr,
   output logic [ETH_ADDR_W-1:0] src_addr,
   output logic [ETH_TYPE_W-1:0] eth_type,
   output logic [ETH_DATA_W-1:0] data_out,
   output logic                  rx_valid,
   output logic                  rx_error,
   output logic                  rx_dropped,
   output logic                  rx_busy
);

   localparam logic [ETH_CNT_W-1:0] CNT_FULL = ETH_CNT_W'(ETH_FRAME_BYTES);
   localparam logic [ETH_CNT_W-1:0] CNT_MAX  = '1;

   rx_state_e                  state_q;
   logic [ETH_CNT_W-1:0]       byte_cnt_q;
   logic [ETH_CNT_W-1:0]       byte_cnt_d;
   logic [ETH_FRAME_W-1:0]     stage_q;
   logic [ETH_FRAME_W-1:0]     stage_d;
   logic [ETH_ADDR_W-1:0]      dest_q;
   logic [ETH_ADDR_W-1:0]      src_q;
   logic [ETH_TYPE_W-1:0]      type_q;
   logic [ETH_DATA_W-1:0]      data_q;
   logic                       valid_q;
   logic                       error_q;
   logic                       dropped_q;
   logic [ETH_ADDR_W-1:0]      stage_dest;
   logic                       accept;

   // Staged field views; byte 0 sits at the top of the shift register.
   assign stage_dest = stage_q[ETH_FRAME_W-1 -: ETH_ADDR_W];

   always_comb begin
      stage_d    = {stage_q[ETH_FRAME_W-ETH_BYTE_W-1:0], rx_in};
      byte_cnt_d = (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + ETH_CNT_W'(1);
   end

   eth_addr_filter u_filter (
      .dest_i     (stage_dest),
      .mac_addr_i (MAC_ADDR),
      .promisc_i  (PROMISC),
      .accept_c   (accept)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= SYNC;
         byte_cnt_q <= '0;
         stage_q    <= '0;
         dest_q     <= '0;
         src_q      <= '0;
         type_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         dropped_q <= 1'b0;
         case (state_q)
            // Never start mid-frame: require a quiet cycle first.
            SYNC: begin
               if (!rx_en) state_q <= IDLE;
            end
            IDLE: begin
               if (rx_en) begin
                  stage_q    <= stage_d;
                  byte_cnt_q <= ETH_CNT_W'(1);
                  state_q    <= RECV;
               end
            end
            RECV: begin
               if (rx_en) begin
                  stage_q    <= stage_d;
                  byte_cnt_q <= byte_cnt_d;
                  if (byte_cnt_q == CNT_FULL) state_q <= OVERRUN;
               end else begin
                  state_q <= IDLE;
                  if (byte_cnt_q != CNT_FULL) begin
                     error_q <= 1'b1;
                  end else if (accept) begin
                     dest_q  <= stage_q[ETH_FRAME_W-1 -: ETH_ADDR_W];
                     src_q   <= stage_q[ETH_FRAME_W-ETH_ADDR_W-1 -: ETH_ADDR_W];
                     type_q  <= stage_q[ETH_DATA_W+ETH_TYPE_W-1 -: ETH_TYPE_W];
                     data_q  <= stage_q[ETH_DATA_W-1:0];
                     valid_q <= 1'b1;
                  end else begin
                     dropped_q <= 1'b1;
                  end
               end
            end
            OVERRUN: begin
               if (!rx_en) begin
                  error_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= SYNC;
         endcase
      end
   end

   assign dest_addr  = dest_q;
   assign src_addr   = src_q;
   assign eth_type   = type_q;
   assign data_out   = data_q;
   assign rx_valid   = valid_q;
   assign rx_error   = error_q;
   assign rx_dropped = dropped_q;
   assign rx_busy    = (state_q == RECV) || (state_q == OVERRUN);

endmodule

// File: tb/tb_frame_reception.sv
// Directed bench for frame_reception: a filtering instance and a promiscuous
// instance share one byte stream driven the way the transmitter drives it.
module tb_frame_reception;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rx_en;
   logic [7:0]   rx_in;

   logic [47:0]  d_dest, d_src, p_dest, p_src;
   logic [15:0]  d_type, p_type;
   logic [31:0]  d_data, p_data;
   logic         d_valid, d_error, d_dropped, d_busy;
   logic         p_valid, p_error, p_dropped, p_busy;

   int checks = 0;
   int errors = 0;

   logic [143:0] exp_fd;
   logic [143:0] exp_fp;

   typedef struct {
      logic [47:0] dest;
      logic [47:0] src;
      logic [15:0] typ;
      logic [31:0] data;
      int          n;
      logic [2:0]  exp_d;   // {valid, error, dropped} of the filtering instance
      logic [2:0]  exp_p;   // same for the promiscuous instance
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   frame_reception #(.MAC_ADDR(48'h1234_5678_9ABC), .PROMISC(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_in(rx_in),
      .dest_addr(d_dest), .src_addr(d_src), .eth_type(d_type), .data_out(d_data),
      .rx_valid(d_valid), .rx_error(d_error), .rx_dropped(d_dropped), .rx_busy(d_busy)
   );

   frame_reception #(.MAC_ADDR(48'h1234_5678_9ABC), .PROMISC(1'b1)) u_prm (
      .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_in(rx_in),
      .dest_addr(p_dest), .src_addr(p_src), .eth_type(p_type), .data_out(p_data),
      .rx_valid(p_valid), .rx_error(p_error), .rx_dropped(p_dropped), .rx_busy(p_busy)
   );

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_byte(input logic [143:0] frame, input int i);
      logic [143:0] tmp;
      tmp = frame >> (8 * (17 - i));
      return tmp[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one frame starting in the current cycle, then check the result cycle.
   task automatic send_and_check(input vec_t v, input int idx);
      logic [143:0] frame;
      logic         busy_ok;
      frame   = {v.dest, v.src, v.typ, v.data};
      busy_ok = 1'b1;
      for (int i = 0; i < v.n; i++) begin
         rx_en = 1'b1;
         rx_in = (i < 18) ? frame_byte(frame, i) : 8'h55;
         tick();
         busy_ok = busy_ok & d_busy & p_busy;
      end
      rx_en = 1'b0;
      rx_in = 8'h00;
      check($sformatf("v%0d busy_during", idx), 160'(busy_ok), 160'(1'b1));
      check($sformatf("v%0d no_early_pulse", idx),
            160'({d_valid, d_error, d_dropped, p_valid, p_error, p_dropped}), 160'(6'b0));
      tick();
      if (v.exp_d[2]) exp_fd = frame;
      if (v.exp_p[2]) exp_fp = frame;
      check($sformatf("v%0d dut_pulse", idx), 160'({d_valid, d_error, d_dropped}), 160'(v.exp_d));
      check($sformatf("v%0d prm_pulse", idx), 160'({p_valid, p_error, p_dropped}), 160'(v.exp_p));
      check($sformatf("v%0d dut_fields", idx), 160'({d_dest, d_src, d_type, d_data}), 160'(exp_fd));
      check($sformatf("v%0d prm_fields", idx), 160'({p_dest, p_src, p_type, p_data}), 160'(exp_fp));
      check($sformatf("v%0d busy_after", idx), 160'({d_busy, p_busy}), 160'(2'b00));
   endtask

   initial begin
      vecs[0] = '{48'h1234_5678_9ABC, 48'hABCD_EF12_3456, 16'h0800, 32'hDEAD_BEEF, 18, 3'b100, 3'b100};
      vecs[1] = '{48'hFFFF_FFFF_FFFF, 48'h1111_1111_1111, 16'h86DD, 32'h0102_0304, 18, 3'b100, 3'b100};
      vecs[2] = '{48'h0200_0000_0001, 48'hABCD_EF12_3456, 16'h0800, 32'h0BAD_F00D, 18, 3'b001, 3'b100};
      vecs[3] = '{48'h1234_5678_9ABC, 48'h2222_2222_2222, 16'h0806, 32'h1122_3344, 17, 3'b010, 3'b010};
      vecs[4] = '{48'h1234_5678_9ABC, 48'h3333_3333_3333, 16'h0806, 32'h5566_7788, 20, 3'b010, 3'b010};
      vecs[5] = '{48'h1234_5678_9ABC, 48'h4444_4444_4444, 16'h0806, 32'h99AA_BBCC, 1,  3'b010, 3'b010};
      vecs[6] = '{48'h1234_5678_9ABC, 48'h5555_5555_5555, 16'h0800, 32'h0000_0001, 19, 3'b010, 3'b010};
      vecs[7] = '{48'h1234_5678_9ABC, 48'hABCD_EF12_3456, 16'h0800, 32'hDEAD_BEEF, 18, 3'b100, 3'b100};
      vecs[8] = '{48'h1234_5678_9ABC, 48'hABCD_EF12_3456, 16'h0800, 32'hCAFE_F00D, 18, 3'b100, 3'b100};

      exp_fd = '0;
      exp_fp = '0;
      rst_n  = 1'b0;
      rx_en  = 1'b0;
      rx_in  = 8'h00;
      repeat (3) tick();
      check("reset_dut", 160'({d_dest, d_src, d_type, d_data, d_valid, d_error, d_dropped, d_busy}), 160'(0));
      check("reset_prm", 160'({p_dest, p_src, p_type, p_data, p_valid, p_error, p_dropped, p_busy}), 160'(0));
      rst_n = 1'b1;
      tick();

      // Consecutive frames: each result cycle is also the next frame's first byte.
      for (int k = 0; k < 9; k++) send_and_check(vecs[k], k);

      // Reset in the middle of a frame, release while the frame continues.
      rx_en = 1'b0;
      tick();
      begin
         logic [143:0] fr;
         fr = {vecs[8].dest, vecs[8].src, vecs[8].typ, vecs[8].data};
         for (int i = 0; i < 7; i++) begin
            rx_en = 1'b1;
            rx_in = frame_byte(fr, i);
            tick();
         end
         rst_n = 1'b0;
         rx_in = frame_byte(fr, 7);
         tick();
         check("midreset_dut", 160'({d_dest, d_src, d_type, d_data, d_valid, d_error, d_dropped, d_busy}), 160'(0));
         check("midreset_prm", 160'({p_dest, p_src, p_type, p_data, p_valid, p_error, p_dropped, p_busy}), 160'(0));
         exp_fd = '0;
         exp_fp = '0;
         rst_n  = 1'b1;
         for (int i = 8; i < 18; i++) begin
            rx_in = frame_byte(fr, i);
            tick();
            check($sformatf("resync_busy_b%0d", i), 160'({d_busy, p_busy}), 160'(2'b00));
         end
         rx_en = 1'b0;
         rx_in = 8'h00;
         tick();
         check("resync_no_pulse_n", 160'({d_valid, d_error, d_dropped, p_valid, p_error, p_dropped}), 160'(0));
         tick();
         check("resync_no_pulse_n1", 160'({d_valid, d_error, d_dropped, p_valid, p_error, p_dropped}), 160'(0));
         check("resync_fields", 160'({d_dest, d_src, d_type, d_data}), 160'(0));
      end
      send_and_check(vecs[0], 100);

      rx_en = 1'b0;
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_reception.md
# frame_reception

Receive-side counterpart of the byte-serial frame transmitter. It consumes the 8-bit frame stream that `frame_transmission` drives on `tx_out`/`tx_en`, and rebuilds the header and payload fields. It applies destination-address filtering and length checking, then presents one complete frame per `rx_valid` pulse to the MAC client logic. Frame format on the wire: dest(6) → src(6) → type(2) → data(4), 18 bytes, each field MSB byte first, no preamble or FCS.

## Interface
- `MAC_ADDR`, default 48'h123456789ABC: station address accepted by the filter.
- `PROMISC`, default 0: when 1, accept every destination address.
- `clk` input 1: single clock, all logic on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `rx_en` input 1: byte valid; high for the full frame, low between frames (connects to `tx_en`).
- `rx_in` input 8: byte stream (connects to `tx_out`).
- `dest_addr` output 48: destination address of the last accepted frame.
- `src_addr` output 48: source address of the last accepted frame.
- `eth_type` output 16: EtherType of the last accepted frame.
- `data_out` output 32: payload of the last accepted frame.
- `rx_valid` output 1: one-cycle pulse; the field outputs were just updated.
- `rx_error` output 1: one-cycle pulse on a short or long frame.
- `rx_dropped` output 1: one-cycle pulse on a well-formed frame rejected by the filter.
- `rx_busy` output 1: high while a frame is being received (states RECV and OVERRUN).

## Operation
- States:
  - SYNC (reset state): wait for `rx_en`=0, then go to IDLE. This stops reception from starting part-way through a frame.
  - IDLE: on `rx_en`=1, capture `rx_in` as byte 0, set `byte_cnt`=1, go to RECV.
  - RECV: while `rx_en`=1, shift `rx_in` into the staging register and increment `byte_cnt`. On the 19th byte (`byte_cnt`==18 with `rx_en`=1), go to OVERRUN. On `rx_en`=0, evaluate the frame and go to IDLE.
  - OVERRUN: ignore bytes; on `rx_en`=0, flag an error and go to IDLE.
- Staging: a 144-bit shift register, new byte entering the LSB. Byte 0 ends up in bits [143:136].
- Evaluation when `rx_en` falls in RECV:
  - `byte_cnt`≠18 → `rx_error`.
  - Otherwise, if dest == `MAC_ADDR`, dest == 48'hFFFFFFFFFFFF, or `PROMISC` → load all four field outputs and pulse `rx_valid`.
  - Otherwise → `rx_dropped`.
- Field outputs change only on an accepted frame. They hold their value through later receptions, errors and drops.
- At most one of `rx_valid`, `rx_error`, `rx_dropped` is high in any cycle.

## Timing
- Reset: all outputs 0, state SYNC, `byte_cnt` 0, staging register cleared.
- Reset mid-frame: the partial frame is discarded with no pulse. After release the block stays in SYNC until `rx_en` is sampled low.
- Latency: let cycle N be the first cycle in which `rx_en` is sampled low after the last byte. The result pulse is high in cycle N+1, and the field outputs are valid in that same cycle.
- Minimum gap between frames is one `rx_en`-low cycle. A frame whose `rx_en` rises in cycle N+1, while the previous result pulse is high, is received normally.
- Edge cases:
  - A zero-length frame cannot occur, since `rx_en` high for one cycle is a 1-byte frame → `rx_error`.
  - `byte_cnt` is 5 bits and saturates, so it never wraps.
  - `rx_busy` goes high in the cycle after the first byte is captured and low in the cycle the result pulse is high.

## Structure
- Shared package `eth_pkg` holds the following, and is shared with `frame_transmission`:
  - `ETH_FRAME_BYTES`=18, `ETH_ADDR_BYTES`=6, `ETH_TYPE_BYTES`=2, `ETH_DATA_BYTES`=4.
  - `ETH_BROADCAST`=48'hFFFFFFFFFFFF.
  - The receive state enum (SYNC, IDLE, RECV, OVERRUN).
- One combinational sub-module, `eth_addr_filter`: inputs dest, `MAC_ADDR`, `PROMISC`; output accept. The same filter is reusable by later RX blocks.
- The FSM, counter, staging register and output registers live in `frame_reception`.

## Test plan
1. **Accepted frame.** Reset, then 18 bytes of dest 123456789ABC, src ABCDEF123456, type 0800, data DEADBEEF, then `rx_en` low.
   - → `rx_valid` for one cycle, two cycles after the last byte.
   - → Outputs equal exactly those values.
   - → `rx_error`/`rx_dropped` stay 0.
2. **Broadcast and filter.**
   - Dest FFFFFFFFFFFF → `rx_valid`.
   - Dest 020000000001 with `PROMISC`=0 → `rx_dropped`; outputs keep the previous frame's values.
   - Same frame with `PROMISC`=1 → `rx_valid`.
3. **Length errors.**
   - 17-byte frame → `rx_error`, outputs unchanged.
   - 20-byte frame → `rx_busy` high throughout; `rx_error` one cycle after `rx_en` falls; no `rx_valid`.
4. **Back-to-back frames.** Two valid frames separated by one idle cycle, payloads DEADBEEF then CAFEF00D → two `rx_valid` pulses; `data_out` = DEADBEEF, then CAFEF00D.
5. **Reset mid-frame.**
   - Assert `rst_n`=0 at byte 7 → all outputs 0.
   - Release with `rx_en` still high for the remaining bytes → no pulse.
   - The next full frame after an idle cycle → `rx_valid`.
6. **Loopback.** `frame_transmission` connected to `frame_reception`, with start and the test 1 values → `rx_valid` with fields identical to the transmitter inputs.
